// File: rtl/pipe_stall_flush_ctrl.sv
// Pipeline stall/flush controller: turns the 5-bit halt vector and taken_branch into
// per-stage load enables, NOP bubbles, branch flushes and stretched stalls.
module pipe_stall_flush_ctrl #(
    parameter int STALL_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       halt,
    input  logic             taken_branch,
    output logic [4:0]       stage_en,
    output logic [4:0]       bubble,
    output logic             flush_id,
    output logic             flush_ex,
    output logic             pc_redirect,
    output logic             busy,
    output logic             halt_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int RW = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;
    localparam logic [RW-1:0]    RELOAD  = RW'(STALL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {S_RUN, S_STALL} state_t;

    state_t           r_state, w_state_nxt;
    logic [4:0]       r_latched, w_latched_nxt;
    logic [RW-1:0]    r_remain, w_remain_nxt;
    logic             r_pending, w_pending_nxt;
    logic             r_halt_err;
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

    logic [4:0]       w_eff;
    logic [4:0]       w_mask;
    logic             w_apply;
    logic             w_stalled;

    // A halted stage also halts everything upstream (higher bit index).
    always_comb begin
        w_eff[0] = halt[0];
        for (int i = 1; i < 5; i++) begin
            w_eff[i] = w_eff[i-1] | halt[i];
        end
    end

    assign w_mask  = w_eff | ((r_state == S_STALL) ? r_latched : 5'b00000);
    assign w_apply = ~w_mask[2] & (taken_branch | r_pending);

    always_comb begin
        stage_en    = 5'b00000;
        bubble      = 5'b00000;
        flush_id    = 1'b0;
        flush_ex    = 1'b0;
        pc_redirect = 1'b0;
        if (rst) begin
            if (w_apply) begin
                stage_en    = 5'b11111;
                flush_id    = 1'b1;
                flush_ex    = 1'b1;
                pc_redirect = 1'b1;
            end else begin
                stage_en = ~w_mask;
                bubble   = {1'b0, w_mask[4:1] & ~w_mask[3:0]};
            end
        end
    end

    assign w_stalled   = (stage_en != 5'b11111);
    assign busy        = (r_state == S_STALL);
    assign halt_err    = r_halt_err;
    assign stall_cnt   = r_stall_cnt;
    assign flush_cnt   = r_flush_cnt;

    always_comb begin
        w_state_nxt   = r_state;
        w_latched_nxt = r_latched;
        w_remain_nxt  = r_remain;
        w_pending_nxt = r_pending;

        if (w_apply) begin
            w_pending_nxt = 1'b0;
        end else if (w_mask[2] & taken_branch) begin
            w_pending_nxt = 1'b1;
        end

        case (r_state)
            S_RUN: begin
                if (!w_apply && (w_eff != 5'b00000) && (STALL_CYCLES > 1)) begin
                    w_state_nxt   = S_STALL;
                    w_latched_nxt = w_eff;
                    w_remain_nxt  = RELOAD;
                end
            end
            S_STALL: begin
                if (w_apply) begin
                    w_state_nxt   = S_RUN;
                    w_latched_nxt = 5'b00000;
                    w_remain_nxt  = '0;
                end else begin
                    w_latched_nxt = r_latched | w_eff;
                    // Last stretched cycle: leave only if no new halt is being requested.
                    if (r_remain <= RW'(1)) begin
                        if (w_eff == 5'b00000) begin
                            w_state_nxt   = S_RUN;
                            w_latched_nxt = 5'b00000;
                            w_remain_nxt  = '0;
                        end else begin
                            w_remain_nxt = RELOAD;
                        end
                    end else begin
                        w_remain_nxt = r_remain - RW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt   = S_RUN;
                w_latched_nxt = 5'b00000;
                w_remain_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_RUN;
            r_latched   <= 5'b00000;
            r_remain    <= '0;
            r_pending   <= 1'b0;
            r_halt_err  <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_latched  <= w_latched_nxt;
            r_remain   <= w_remain_nxt;
            r_pending  <= w_pending_nxt;
            r_halt_err <= r_halt_err | (halt != w_eff);
            if (w_stalled && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_apply && (r_flush_cnt != CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_stall_flush_ctrl.sv
// Bench for pipe_stall_flush_ctrl: three instances (1-cycle stall, 3-cycle stretch,
// 4-bit counters) driven from shared inputs; vector table plus multi-cycle sequences.
module tb_pipe_stall_flush_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] halt;
    logic       taken_branch;

    logic [4:0]  s1_en, s1_bub, s3_en, s3_bub, c4_en, c4_bub;
    logic        s1_fid, s1_fex, s1_pr, s1_busy, s1_err;
    logic        s3_fid, s3_fex, s3_pr, s3_busy, s3_err;
    logic        c4_fid, c4_fex, c4_pr, c4_busy, c4_err;
    logic [15:0] s1_scnt, s1_fcnt, s3_scnt, s3_fcnt;
    logic [3:0]  c4_scnt, c4_fcnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0] halt;
        logic       br;
        logic [4:0] en;
        logic [4:0] bub;
        logic [2:0] fl;   // {pc_redirect, flush_id, flush_ex}
    } vec_t;

    vec_t vecs[11];

    pipe_stall_flush_ctrl #(.STALL_CYCLES(1), .CNT_W(16)) u_s1 (
        .clk(clk), .rst(rst), .halt(halt), .taken_branch(taken_branch),
        .stage_en(s1_en), .bubble(s1_bub), .flush_id(s1_fid), .flush_ex(s1_fex),
        .pc_redirect(s1_pr), .busy(s1_busy), .halt_err(s1_err),
        .stall_cnt(s1_scnt), .flush_cnt(s1_fcnt));

    pipe_stall_flush_ctrl #(.STALL_CYCLES(3), .CNT_W(16)) u_s3 (
        .clk(clk), .rst(rst), .halt(halt), .taken_branch(taken_branch),
        .stage_en(s3_en), .bubble(s3_bub), .flush_id(s3_fid), .flush_ex(s3_fex),
        .pc_redirect(s3_pr), .busy(s3_busy), .halt_err(s3_err),
        .stall_cnt(s3_scnt), .flush_cnt(s3_fcnt));

    pipe_stall_flush_ctrl #(.STALL_CYCLES(1), .CNT_W(4)) u_c4 (
        .clk(clk), .rst(rst), .halt(halt), .taken_branch(taken_branch),
        .stage_en(c4_en), .bubble(c4_bub), .flush_id(c4_fid), .flush_ex(c4_fex),
        .pc_redirect(c4_pr), .busy(c4_busy), .halt_err(c4_err),
        .stall_cnt(c4_scnt), .flush_cnt(c4_fcnt));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst = 1'b0;
        halt = 5'b00000;
        taken_branch = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{5'b00000, 1'b0, 5'b11111, 5'b00000, 3'b000};
        vecs[1]  = '{5'b11100, 1'b0, 5'b00011, 5'b00010, 3'b000};
        vecs[2]  = '{5'b00000, 1'b0, 5'b11111, 5'b00000, 3'b000};
        vecs[3]  = '{5'b10000, 1'b0, 5'b01111, 5'b01000, 3'b000};
        vecs[4]  = '{5'b00000, 1'b1, 5'b11111, 5'b00000, 3'b111};
        vecs[5]  = '{5'b11000, 1'b1, 5'b11111, 5'b00000, 3'b111};
        vecs[6]  = '{5'b11111, 1'b1, 5'b00000, 5'b00000, 3'b000};
        vecs[7]  = '{5'b00000, 1'b0, 5'b11111, 5'b00000, 3'b111};
        vecs[8]  = '{5'b00000, 1'b0, 5'b11111, 5'b00000, 3'b000};
        vecs[9]  = '{5'b11110, 1'b0, 5'b00001, 5'b00001, 3'b000};
        vecs[10] = '{5'b00000, 1'b0, 5'b11111, 5'b00000, 3'b000};

        // Reset values and release
        rst = 1'b0;
        halt = 5'b00000;
        taken_branch = 1'b0;
        tick();
        settle();
        chk("rst_en_s1", 32'(s1_en), 32'h00);
        chk("rst_en_s3", 32'(s3_en), 32'h00);
        chk("rst_bub", 32'(s1_bub), 32'h00);
        chk("rst_pr", 32'(s1_pr), 32'h0);
        chk("rst_scnt", 32'(s1_scnt), 32'h0);
        chk("rst_fcnt", 32'(s1_fcnt), 32'h0);
        chk("rst_err", 32'(s1_err), 32'h0);
        tick();
        rst = 1'b1;
        settle();
        chk("rel_en", 32'(s1_en), 32'h1f);
        chk("rel_bub", 32'(s1_bub), 32'h00);
        tick();

        // Vector table on the single-cycle instance
        for (int i = 0; i < 11; i++) begin
            halt = vecs[i].halt;
            taken_branch = vecs[i].br;
            settle();
            chk($sformatf("vec%0d_en", i), 32'(s1_en), 32'(vecs[i].en));
            chk($sformatf("vec%0d_bub", i), 32'(s1_bub), 32'(vecs[i].bub));
            chk($sformatf("vec%0d_fl", i), 32'({s1_pr, s1_fid, s1_fex}), 32'(vecs[i].fl));
            chk($sformatf("vec%0d_busy", i), 32'(s1_busy), 32'h0);
            tick();
        end
        halt = 5'b00000;
        taken_branch = 1'b0;
        settle();
        chk("tbl_scnt", 32'(s1_scnt), 32'd4);
        chk("tbl_fcnt", 32'(s1_fcnt), 32'd3);
        chk("tbl_err", 32'(s1_err), 32'h0);
        tick();

        // Stretched stall: one-cycle halt pulse held for three cycles
        do_reset();
        halt = 5'b11000;
        settle();
        chk("st_c1_en", 32'(s3_en), 32'h07);
        chk("st_c1_bub", 32'(s3_bub), 32'h04);
        chk("st_c1_busy", 32'(s3_busy), 32'h0);
        tick();
        halt = 5'b00000;
        settle();
        chk("st_c2_en", 32'(s3_en), 32'h07);
        chk("st_c2_bub", 32'(s3_bub), 32'h04);
        chk("st_c2_busy", 32'(s3_busy), 32'h1);
        tick();
        settle();
        chk("st_c3_en", 32'(s3_en), 32'h07);
        chk("st_c3_busy", 32'(s3_busy), 32'h1);
        tick();
        settle();
        chk("st_c4_en", 32'(s3_en), 32'h1f);
        chk("st_c4_busy", 32'(s3_busy), 32'h0);
        chk("st_scnt", 32'(s3_scnt), 32'd3);
        tick();

        // Non-thermometer halt sets the sticky error
        do_reset();
        halt = 5'b01000;
        settle();
        chk("err_en", 32'(s1_en), 32'h07);
        chk("err_bub", 32'(s1_bub), 32'h04);
        chk("err_c1", 32'(s1_err), 32'h0);
        tick();
        halt = 5'b00000;
        settle();
        chk("err_c2", 32'(s1_err), 32'h1);
        chk("err_c2_en", 32'(s1_en), 32'h1f);
        tick();
        settle();
        chk("err_sticky", 32'(s1_err), 32'h1);
        tick();

        // Branch while EX halted is deferred one cycle
        do_reset();
        halt = 5'b11100;
        taken_branch = 1'b1;
        settle();
        chk("pend_c1_pr", 32'(s1_pr), 32'h0);
        chk("pend_c1_en", 32'(s1_en), 32'h03);
        tick();
        halt = 5'b00000;
        taken_branch = 1'b0;
        settle();
        chk("pend_c2_fl", 32'({s1_pr, s1_fid, s1_fex}), 32'h7);
        chk("pend_c2_en", 32'(s1_en), 32'h1f);
        tick();
        settle();
        chk("pend_c3_pr", 32'(s1_pr), 32'h0);
        chk("pend_fcnt", 32'(s1_fcnt), 32'd1);
        tick();

        // Branch arriving mid-stretch with EX free ends the stall
        do_reset();
        halt = 5'b11000;
        settle();
        chk("bst_c1_en", 32'(s3_en), 32'h07);
        tick();
        halt = 5'b00000;
        taken_branch = 1'b1;
        settle();
        chk("bst_c2_pr", 32'(s3_pr), 32'h1);
        chk("bst_c2_en", 32'(s3_en), 32'h1f);
        chk("bst_c2_bub", 32'(s3_bub), 32'h00);
        tick();
        taken_branch = 1'b0;
        settle();
        chk("bst_c3_busy", 32'(s3_busy), 32'h0);
        chk("bst_c3_en", 32'(s3_en), 32'h1f);
        chk("bst_fcnt", 32'(s3_fcnt), 32'd1);
        tick();

        // Pending branch waits out the whole stretched stall
        do_reset();
        halt = 5'b11100;
        taken_branch = 1'b1;
        settle();
        chk("pst_c1_pr", 32'(s3_pr), 32'h0);
        chk("pst_c1_en", 32'(s3_en), 32'h03);
        tick();
        halt = 5'b00000;
        taken_branch = 1'b0;
        settle();
        chk("pst_c2_pr", 32'(s3_pr), 32'h0);
        chk("pst_c2_busy", 32'(s3_busy), 32'h1);
        chk("pst_c2_en", 32'(s3_en), 32'h03);
        tick();
        settle();
        chk("pst_c3_pr", 32'(s3_pr), 32'h0);
        chk("pst_c3_busy", 32'(s3_busy), 32'h1);
        tick();
        settle();
        chk("pst_c4_pr", 32'(s3_pr), 32'h1);
        chk("pst_c4_busy", 32'(s3_busy), 32'h0);
        chk("pst_c4_en", 32'(s3_en), 32'h1f);
        tick();

        // Reset mid-stall with a pending branch drops both
        do_reset();
        halt = 5'b11100;
        taken_branch = 1'b1;
        settle();
        tick();
        halt = 5'b00000;
        taken_branch = 1'b0;
        settle();
        chk("rms_busy", 32'(s3_busy), 32'h1);
        rst = 1'b0;
        #1;
        chk("rms_rst_busy", 32'(s3_busy), 32'h0);
        chk("rms_rst_en", 32'(s3_en), 32'h00);
        chk("rms_rst_pr", 32'(s3_pr), 32'h0);
        tick();
        rst = 1'b1;
        settle();
        chk("rms_rel_en", 32'(s3_en), 32'h1f);
        chk("rms_rel_pr", 32'(s3_pr), 32'h0);
        tick();
        settle();
        chk("rms_c2_pr", 32'(s3_pr), 32'h0);
        chk("rms_fcnt", 32'(s3_fcnt), 32'd0);
        tick();

        // Stall counter saturation with 4-bit counters
        do_reset();
        halt = 5'b00001;
        for (int i = 0; i < 20; i++) begin
            settle();
            chk($sformatf("sat%0d_en", i), 32'(c4_en), 32'h00);
            chk($sformatf("sat%0d_bub", i), 32'(c4_bub), 32'h00);
            tick();
        end
        halt = 5'b00000;
        settle();
        chk("sat_scnt", 32'(c4_scnt), 32'd15);
        chk("sat_en", 32'(c4_en), 32'h1f);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
